// File: rtl/mux_scan_serializer.sv
// Word-to-serial sequencer for an external 8:1 mux: latches a word, walks mux_sel, streams mux_out.
// Optional even-parity trailer bit when MUX_SCAN_PARITY_EN is defined.
`timescale 1ns/1ps
module mux_scan_serializer #(
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic [7:0] mux_x,
    output logic [2:0] mux_sel,
    input  logic       mux_out,
    output logic       ser_valid,
    input  logic       ser_ready,
    output logic       ser_data,
    output logic       ser_last,
    output logic       busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [2:0] FIRST_IDX = (MSB_FIRST != 0) ? 3'd7 : 3'd0;
    localparam logic [2:0] FINAL_IDX = (MSB_FIRST != 0) ? 3'd0 : 3'd7;

    logic [1:0] state_q, state_d;
    logic [7:0] mux_x_q, mux_x_d;
    logic [2:0] sel_q, sel_d;
    logic       ser_valid_q, ser_valid_d;
    logic       ser_data_q, ser_data_d;
    logic       ser_last_q, ser_last_d;
    logic       in_ready_q, in_ready_d;
    logic       busy_q, busy_d;
    logic       advance;
    logic [2:0] sel_step;
`ifdef MUX_SCAN_PARITY_EN
    logic       par_q, par_d;
    logic       par_phase_q, par_phase_d;
`endif

    assign advance  = !ser_valid_q || ser_ready;
    assign sel_step = (MSB_FIRST != 0) ? (sel_q - 3'd1) : (sel_q + 3'd1);

    always_comb begin
        state_d     = state_q;
        mux_x_d     = mux_x_q;
        sel_d       = sel_q;
        ser_valid_d = ser_valid_q;
        ser_data_d  = ser_data_q;
        ser_last_d  = ser_last_q;
`ifdef MUX_SCAN_PARITY_EN
        par_d       = par_q;
        par_phase_d = par_phase_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    mux_x_d = in_data;
                    sel_d   = FIRST_IDX;
                    state_d = SCAN;
`ifdef MUX_SCAN_PARITY_EN
                    par_d       = ^in_data;
                    par_phase_d = 1'b0;
`endif
                end
            end
            SCAN: begin
                if (advance) begin
                    ser_valid_d = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                    // Trailer bit comes from the latched parity, not the mux.
                    if (par_phase_q) begin
                        ser_data_d = par_q;
                        ser_last_d = 1'b1;
                        state_d    = DRAIN;
                    end else begin
                        ser_data_d = mux_out;
                        ser_last_d = 1'b0;
                        if (sel_q == FINAL_IDX) begin
                            par_phase_d = 1'b1;
                        end else begin
                            sel_d = sel_step;
                        end
                    end
`else
                    ser_data_d = mux_out;
                    ser_last_d = (sel_q == FINAL_IDX);
                    if (sel_q == FINAL_IDX) begin
                        state_d = DRAIN;
                    end else begin
                        sel_d = sel_step;
                    end
`endif
                end
            end
            DRAIN: begin
                if (ser_ready) begin
                    ser_valid_d = 1'b0;
                    ser_last_d  = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mux_x_q     <= 8'd0;
            sel_q       <= 3'd0;
            ser_valid_q <= 1'b0;
            ser_data_q  <= 1'b0;
            ser_last_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            par_q       <= 1'b0;
            par_phase_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mux_x_q     <= mux_x_d;
            sel_q       <= sel_d;
            ser_valid_q <= ser_valid_d;
            ser_data_q  <= ser_data_d;
            ser_last_q  <= ser_last_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
`ifdef MUX_SCAN_PARITY_EN
            par_q       <= par_d;
            par_phase_q <= par_phase_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign mux_x     = mux_x_q;
    assign mux_sel   = sel_q;
    assign ser_valid = ser_valid_q;
    assign ser_data  = ser_data_q;
    assign ser_last  = ser_last_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_mux_scan_serializer.sv
// Scoreboard bench: LSB-first and MSB-first instances share stimulus; expected bit streams come from the word.
`timescale 1ns/1ps
module tb_mux_scan_serializer;
`ifdef MUX_SCAN_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif
    localparam int PERIOD = NBITS + 2;

    typedef struct {
        logic       d;
        logic       l;
        logic [2:0] s;
        logic [7:0] x;
    } item_t;

    logic       clk, rst_n, in_valid, ser_ready;
    logic [7:0] in_data;
    logic [1:0] in_rdy, sv, sd, sl, bz, mo;
    logic [2:0] sel [2];
    logic [7:0] mx  [2];

    item_t q0[$];
    item_t q1[$];
    int checks, errors, cyc, acc_n, acc_cyc;
    bit stim_done;

    mux_scan_serializer #(.MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[0]), .in_data(in_data),
        .mux_x(mx[0]), .mux_sel(sel[0]), .mux_out(mo[0]), .ser_valid(sv[0]), .ser_ready(ser_ready),
        .ser_data(sd[0]), .ser_last(sl[0]), .busy(bz[0]));
    mux_scan_serializer #(.MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[1]), .in_data(in_data),
        .mux_x(mx[1]), .mux_sel(sel[1]), .mux_out(mo[1]), .ser_valid(sv[1]), .ser_ready(ser_ready),
        .ser_data(sd[1]), .ser_last(sl[1]), .busy(bz[1]));

    // External 8:1 mux model
    assign mo[0] = mx[0][sel[0]];
    assign mo[1] = mx[1][sel[1]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input int id, input logic [7:0] w);
        item_t it;
        for (int j = 0; j < 8; j++) begin
            int idx, nxt;
            idx  = (id != 0) ? 7 - j : j;
            nxt  = (j < 7) ? ((id != 0) ? 6 - j : j + 1) : ((id != 0) ? 0 : 7);
            it.d = w[idx];
            it.l = (j == 7) && (NBITS == 8);
            it.s = 3'(nxt);
            it.x = w;
            if (id == 0) q0.push_back(it); else q1.push_back(it);
        end
`ifdef MUX_SCAN_PARITY_EN
        it.d = ^w;
        it.l = 1'b1;
        it.s = (id != 0) ? 3'd0 : 3'd7;
        it.x = w;
        if (id == 0) q0.push_back(it); else q1.push_back(it);
`endif
    endtask

    task automatic mon(input int id);
        item_t e;
        if (sv[id]) begin
            chk($sformatf("busy_with_valid[%0d]", id), bz[id], 1);
            if ((id == 0 ? q0.size() : q1.size()) == 0) begin
                chk($sformatf("unexpected_bit[%0d]", id), sv[id], 0);
            end else begin
                e = (id == 0) ? q0[0] : q1[0];
                chk($sformatf("ser_data[%0d]", id), sd[id], e.d);
                chk($sformatf("ser_last[%0d]", id), sl[id], e.l);
                chk($sformatf("mux_sel[%0d]", id), sel[id], e.s);
                chk($sformatf("mux_x[%0d]", id), mx[id], e.x);
                if (ser_ready) begin
                    if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                end
            end
        end
    endtask

    // Accept tracking and output monitoring, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            mon(0);
            mon(1);
            for (int i = 0; i < 2; i++) begin
                if (in_valid && in_rdy[i]) begin
                    push_frame(i, in_data);
                    if (i == 0) begin
                        acc_n++;
                        acc_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] w);
        int n;
        in_valid = 1'b1;
        in_data  = w;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (in_rdy[0]) break;
            n++;
        end
        if (n >= 100) chk("send_timeout", in_rdy[0], 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 60 && (bz != 2'b00 || in_rdy != 2'b11)) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 60) chk("idle_timeout", bz, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_ser_valid[%0d]", tag, i), sv[i], 0);
            chk($sformatf("%s_mux_sel[%0d]", tag, i), sel[i], 0);
            chk($sformatf("%s_mux_x[%0d]", tag, i), mx[i], 0);
            chk($sformatf("%s_busy[%0d]", tag, i), bz[i], 0);
            chk($sformatf("%s_ser_last[%0d]", tag, i), sl[i], 0);
        end
    endtask

    initial begin
        int n, c0;
        checks = 0; errors = 0; cyc = 0; acc_n = 0; acc_cyc = 0; stim_done = 1'b0;
        in_valid = 1'b0; in_data = 8'd0; ser_ready = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_vals("reset");
        chk("reset_ser_data", sd[0], 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", in_rdy[0], 1);

        // Basic frame and in_ready return time
        send(8'b11010100);
        n = 0;
        while (n < 30 && !in_rdy[0]) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("in_ready_return_cycles", n, PERIOD - 1);
        wait_idle();

        send(8'b11110000);
        wait_idle();

        // Backpressure after the 3rd bit
        send(8'b11001100);
        repeat (3) @(posedge clk);
        #1 ser_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ser_data", sd[0], 1);
            chk("stall_mux_sel", sel[0], 3);
        end
        @(posedge clk);
        #1 ser_ready = 1'b1;
        wait_idle();

        // New word held on in_valid during a frame is taken only once back in IDLE
        send(8'b11010010);
        c0 = acc_cyc;
        n  = acc_n;
        in_valid = 1'b1;
        in_data  = 8'b11111111;
        for (int i = 0; i < 40 && acc_n == n; i++) @(posedge clk);
        chk("second_accept_gap", acc_cyc - c0, PERIOD);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_idle();

        send(8'b11101100);
        wait_idle();

        // Asynchronous reset mid-frame
        send(8'h5A);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1 check_reset_vals("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_midreset", in_rdy[0], 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("no_residual_valid", sv[0] | sv[1], 0);
        end

        // Randomized words with random backpressure
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                    send(8'($urandom));
                end
                stim_done = 1'b1;
            end
            begin
                while (!stim_done) begin
                    @(posedge clk);
                    #1 ser_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        ser_ready = 1'b1;
        wait_idle();
        repeat (2) @(negedge clk);
        chk("scoreboard_empty_lsb", q0.size(), 0);
        chk("scoreboard_empty_msb", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
